// File: rtl/semaforo_arbitro.sv
// Four-approach traffic-light arbiter with pedestrian phase, all-red clearance and
// emergency preemption; round-robin service of sticky vehicle demands.
module semaforo_arbitro #(
   parameter logic [7:0] T_VERDE    = 8'd10,
   parameter logic [7:0] T_AMBAR    = 8'd3,
   parameter logic [7:0] T_TODOROJO = 8'd2,
   parameter logic [7:0] T_PEATON   = 8'd8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [3:0] req,
   input  logic       ped_req,
   input  logic       emerg,
   input  logic [1:0] emerg_dir,
   output logic [3:0] verde,
   output logic [3:0] ambar,
   output logic       peaton,
   output logic [2:0] fase,
   output logic [1:0] dir
);

   localparam logic [2:0] S_TODOROJO = 3'd0;
   localparam logic [2:0] S_VERDE    = 3'd1;
   localparam logic [2:0] S_AMBAR    = 3'd2;
   localparam logic [2:0] S_PEATON   = 3'd3;
   localparam logic [2:0] S_PREEMPT  = 3'd4;

   logic [2:0] state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic [3:0] pend_q, pend_d;
   logic       ped_pend_q, ped_pend_d;
   logic [1:0] dir_q, dir_d;
   logic       last_ped_q, last_ped_d;
   logic [3:0] verde_q, verde_d;
   logic [3:0] ambar_q, ambar_d;
   logic       peaton_q, peaton_d;

   logic [3:0] pend_set_s;
   logic       ped_set_s;
   logic       expire_s;
   logic [2:0] pick_s;

   // Round-robin pick: {found, index}, scanning d+1, d+2, d+3, d.
   function automatic logic [2:0] rr_pick(input logic [3:0] p, input logic [1:0] d);
      logic [2:0] r;
      logic [1:0] idx;
      r = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = d + k[1:0];
         if (p[idx]) begin
            r = {1'b1, idx};
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   assign pend_set_s = pend_q | req;
   assign ped_set_s  = ped_pend_q | ped_req;
   assign expire_s   = tick && (timer_q == 8'd1);
   assign pick_s     = rr_pick(pend_set_s, dir_q);

   // Next-state, timer, demand and pointer logic.
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      last_ped_d = last_ped_q;
      pend_d     = pend_set_s;
      ped_pend_d = ped_set_s;
      if (tick && (timer_q != 8'd0)) begin
         timer_d = timer_q - 8'd1;
      end else begin
         timer_d = timer_q;
      end
      case (state_q)
         S_TODOROJO: begin
            if (expire_s || (timer_q == 8'd0)) begin
               if (emerg) begin
                  state_d           = S_PREEMPT;
                  dir_d             = emerg_dir;
                  pend_d[emerg_dir] = 1'b0;
                  last_ped_d        = 1'b0;
                  timer_d           = 8'd0;
               end else if (ped_set_s && !last_ped_q) begin
                  state_d    = S_PEATON;
                  ped_pend_d = 1'b0;
                  last_ped_d = 1'b1;
                  timer_d    = T_PEATON;
               end else if (pick_s[2]) begin
                  state_d             = S_VERDE;
                  dir_d               = pick_s[1:0];
                  pend_d[pick_s[1:0]] = 1'b0;
                  last_ped_d          = 1'b0;
                  timer_d             = T_VERDE;
               end else begin
                  timer_d = 8'd0;
               end
            end else begin
               state_d = S_TODOROJO;
            end
         end
         S_VERDE: begin
            if (emerg) begin
               if (emerg_dir != dir_q) begin
                  state_d = S_AMBAR;
                  timer_d = T_AMBAR;
               end else begin
                  state_d       = S_PREEMPT;
                  pend_d[dir_q] = 1'b0;
                  last_ped_d    = 1'b0;
                  timer_d       = 8'd0;
               end
            end else if (expire_s) begin
               state_d = S_AMBAR;
               timer_d = T_AMBAR;
            end else begin
               state_d = S_VERDE;
            end
         end
         S_AMBAR: begin
            if (expire_s) begin
               state_d = S_TODOROJO;
               timer_d = T_TODOROJO;
            end else begin
               state_d = S_AMBAR;
            end
         end
         S_PEATON: begin
            if (emerg || expire_s) begin
               state_d = S_TODOROJO;
               timer_d = T_TODOROJO;
            end else begin
               state_d = S_PEATON;
            end
         end
         S_PREEMPT: begin
            // Preemption is untimed; leaves as soon as the request drops or moves.
            if (!emerg || (emerg_dir != dir_q)) begin
               state_d = S_AMBAR;
               timer_d = T_AMBAR;
            end else begin
               timer_d = 8'd0;
            end
         end
         default: begin
            state_d = S_TODOROJO;
            timer_d = T_TODOROJO;
            dir_d   = 2'd3;
         end
      endcase
   end

   // Lamp decode from the upcoming state so the registered lamps track state_q.
   always_comb begin
      verde_d  = 4'b0000;
      ambar_d  = 4'b0000;
      peaton_d = 1'b0;
      case (state_d)
         S_VERDE, S_PREEMPT: verde_d  = 4'b0001 << dir_d;
         S_AMBAR:            ambar_d  = 4'b0001 << dir_d;
         S_PEATON:           peaton_d = 1'b1;
         default:            peaton_d = 1'b0;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_TODOROJO;
         timer_q    <= T_TODOROJO;
         pend_q     <= 4'b0000;
         ped_pend_q <= 1'b0;
         dir_q      <= 2'd3;
         last_ped_q <= 1'b0;
         verde_q    <= 4'b0000;
         ambar_q    <= 4'b0000;
         peaton_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         pend_q     <= pend_d;
         ped_pend_q <= ped_pend_d;
         dir_q      <= dir_d;
         last_ped_q <= last_ped_d;
         verde_q    <= verde_d;
         ambar_q    <= ambar_d;
         peaton_q   <= peaton_d;
      end
   end

   assign verde  = verde_q;
   assign ambar  = ambar_q;
   assign peaton = peaton_q;
   assign fase   = state_q;
   assign dir    = dir_q;

endmodule

// File: tb/tb_semaforo_arbitro.sv
// Directed scoreboard bench for semaforo_arbitro: expected per-cycle lamp/phase
// words are queued with the stimulus and popped one per clock.
module tb_semaforo_arbitro;

   localparam logic [2:0] F_TR = 3'd0;
   localparam logic [2:0] F_VE = 3'd1;
   localparam logic [2:0] F_AM = 3'd2;
   localparam logic [2:0] F_PE = 3'd3;
   localparam logic [2:0] F_PR = 3'd4;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic [3:0] req;
   logic       ped_req;
   logic       emerg;
   logic [1:0] emerg_dir;
   logic [3:0] verde;
   logic [3:0] ambar;
   logic       peaton;
   logic [2:0] fase;
   logic [1:0] dir;

   int          checks   = 0;
   int          failures = 0;
   string       tag;
   logic [13:0] exp_q[$];

   semaforo_arbitro dut (
      .clk(clk), .rst(rst), .tick(tick), .req(req), .ped_req(ped_req),
      .emerg(emerg), .emerg_dir(emerg_dir), .verde(verde), .ambar(ambar),
      .peaton(peaton), .fase(fase), .dir(dir)
   );

   always #5 clk = ~clk;

   // Push n identical expected words {fase, verde, ambar, peaton, dir}.
   task automatic expect_n(input int n, input logic [2:0] f, input logic [3:0] v,
                           input logic [3:0] a, input logic p, input logic [1:0] d);
      for (int i = 0; i < n; i++) exp_q.push_back({f, v, a, p, d});
   endtask

   // Advance n clocks, comparing DUT outputs against the queue head after each edge.
   task automatic run(input int n);
      logic [13:0] e;
      logic [13:0] obs;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         obs = {fase, verde, ambar, peaton, dir};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty observed=%h", tag, obs);
         end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
               failures++;
               $error("FAIL %s observed=%h expected=%h (fase,verde,ambar,peaton,dir)", tag, obs, e);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; tick = 1'b1; req = 4'b0000; ped_req = 1'b0;
      emerg = 1'b0; emerg_dir = 2'd0;

      tag = "reset";
      expect_n(1, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd3);
      run(1);

      tag = "single_grant";
      rst = 1'b0; req = 4'b0001;
      expect_n(1, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd3);
      expect_n(10, F_VE, 4'b0001, 4'b0000, 1'b0, 2'd0);
      expect_n(3, F_AM, 4'b0000, 4'b0001, 1'b0, 2'd0);
      expect_n(4, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd0);
      run(1);
      req = 4'b0000;
      run(17);

      tag = "round_robin";
      req = 4'b1010;
      expect_n(10, F_VE, 4'b0010, 4'b0000, 1'b0, 2'd1);
      expect_n(3, F_AM, 4'b0000, 4'b0010, 1'b0, 2'd1);
      expect_n(2, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd1);
      expect_n(10, F_VE, 4'b1000, 4'b0000, 1'b0, 2'd3);
      expect_n(3, F_AM, 4'b0000, 4'b1000, 1'b0, 2'd3);
      expect_n(4, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd3);
      run(1);
      req = 4'b0000;
      run(31);

      tag = "pedestrian";
      req = 4'b0001;
      expect_n(10, F_VE, 4'b0001, 4'b0000, 1'b0, 2'd0);
      run(1);
      req = 4'b0100; ped_req = 1'b1;
      run(1);
      req = 4'b0000; ped_req = 1'b0;
      expect_n(3, F_AM, 4'b0000, 4'b0001, 1'b0, 2'd0);
      expect_n(2, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd0);
      expect_n(8, F_PE, 4'b0000, 4'b0000, 1'b1, 2'd0);
      expect_n(2, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd0);
      expect_n(10, F_VE, 4'b0100, 4'b0000, 1'b0, 2'd2);
      expect_n(3, F_AM, 4'b0000, 4'b0100, 1'b0, 2'd2);
      expect_n(3, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd2);
      run(39);

      tag = "preempt_other";
      req = 4'b0001;
      expect_n(4, F_VE, 4'b0001, 4'b0000, 1'b0, 2'd0);
      run(1);
      req = 4'b0000;
      run(3);
      emerg = 1'b1; emerg_dir = 2'd2;
      expect_n(3, F_AM, 4'b0000, 4'b0001, 1'b0, 2'd0);
      expect_n(2, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd0);
      expect_n(5, F_PR, 4'b0100, 4'b0000, 1'b0, 2'd2);
      run(10);
      emerg = 1'b0;
      expect_n(3, F_AM, 4'b0000, 4'b0100, 1'b0, 2'd2);
      expect_n(3, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd2);
      run(6);

      tag = "tick_hold";
      req = 4'b0001;
      expect_n(1, F_VE, 4'b0001, 4'b0000, 1'b0, 2'd0);
      run(1);
      req = 4'b0000; tick = 1'b0;
      expect_n(50, F_VE, 4'b0001, 4'b0000, 1'b0, 2'd0);
      run(50);
      tick = 1'b1;
      expect_n(9, F_VE, 4'b0001, 4'b0000, 1'b0, 2'd0);
      expect_n(3, F_AM, 4'b0000, 4'b0001, 1'b0, 2'd0);
      expect_n(3, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd0);
      run(15);

      tag = "mid_reset";
      req = 4'b0010;
      expect_n(3, F_VE, 4'b0010, 4'b0000, 1'b0, 2'd1);
      run(1);
      req = 4'b1000;
      run(1);
      req = 4'b0000;
      run(1);
      rst = 1'b1;
      expect_n(1, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd3);
      run(1);
      rst = 1'b0;
      expect_n(6, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd3);
      run(6);

      tag = "preempt_same";
      req = 4'b0001;
      expect_n(1, F_VE, 4'b0001, 4'b0000, 1'b0, 2'd0);
      run(1);
      req = 4'b0000; emerg = 1'b1; emerg_dir = 2'd0;
      expect_n(3, F_PR, 4'b0001, 4'b0000, 1'b0, 2'd0);
      run(3);
      emerg = 1'b0;
      expect_n(3, F_AM, 4'b0000, 4'b0001, 1'b0, 2'd0);
      expect_n(3, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd0);
      run(6);

      tag = "ped_emerg";
      ped_req = 1'b1;
      expect_n(2, F_PE, 4'b0000, 4'b0000, 1'b1, 2'd0);
      run(1);
      ped_req = 1'b0;
      run(1);
      emerg = 1'b1; emerg_dir = 2'd1;
      expect_n(2, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd0);
      expect_n(2, F_PR, 4'b0010, 4'b0000, 1'b0, 2'd1);
      run(4);
      emerg = 1'b0;
      expect_n(3, F_AM, 4'b0000, 4'b0010, 1'b0, 2'd1);
      expect_n(3, F_TR, 4'b0000, 4'b0000, 1'b0, 2'd1);
      run(6);

      tag = "sb_drain";
      checks++;
      assert (exp_q.size() == 0) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=0 entries left", tag, exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
